// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters.
// Each granted operation runs IDLE -> EXEC -> RESP and returns on a single response port.

module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       alu_control,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero
);

    logic             is_sub_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   sum_s;
    logic             overflow_s;
    logic             slt_s;
    logic             sltu_s;

    // Shared adder: subtract, slt and sltu all use a + ~b + 1.
    always_comb begin
        is_sub_s   = (alu_control == 3'b001) || (alu_control == 3'b101) || (alu_control == 3'b110);
        b_eff_s    = is_sub_s ? ~src_b : src_b;
        sum_s      = {1'b0, src_a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, is_sub_s};
        overflow_s = ~(src_a[WIDTH-1] ^ b_eff_s[WIDTH-1]) & (src_a[WIDTH-1] ^ sum_s[WIDTH-1]);
        slt_s      = sum_s[WIDTH-1] ^ overflow_s;
        sltu_s     = ~sum_s[WIDTH];
    end

    // Result select by control code.
    always_comb begin
        alu_result = {WIDTH{1'b0}};
        case (alu_control)
            3'b000:  alu_result = sum_s[WIDTH-1:0];
            3'b001:  alu_result = sum_s[WIDTH-1:0];
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            3'b101:  alu_result = {{(WIDTH-1){1'b0}}, slt_s};
            3'b110:  alu_result = {{(WIDTH-1){1'b0}}, sltu_s};
            3'b111:  alu_result = src_a << src_b[$clog2(WIDTH)-1:0];
            default: alu_result = {WIDTH{1'b0}};
        endcase
        zero = (alu_result == {WIDTH{1'b0}});
    end

endmodule

module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [OPW-1:0]   req_op0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [OPW-1:0]   req_op1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNTW-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [OPW-1:0]   op_ctl_q, op_ctl_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic [CNTW-1:0]  op_count_q, op_count_d;

    logic             grant_vld_s;
    logic             grant_id_s;
    logic [1:0]       req_ready_s;
    logic [WIDTH-1:0] alu_result_s;
    logic             alu_zero_s;

    // The ALU sees only captured operands, so requesters may change inputs after grant.
    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .src_a       (op_a_q),
        .src_b       (op_b_q),
        .alu_control (op_ctl_q),
        .alu_result  (alu_result_s),
        .zero        (alu_zero_s)
    );

    // Round-robin pick: on contention the requester that did not win last time goes.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
        req_ready_s = 2'b00;
        case (req_valid)
            2'b01: begin
                grant_vld_s = 1'b1;
                grant_id_s  = 1'b0;
            end
            2'b10: begin
                grant_vld_s = 1'b1;
                grant_id_s  = 1'b1;
            end
            2'b11: begin
                grant_vld_s = 1'b1;
                grant_id_s  = ~last_grant_q;
            end
            default: begin
                grant_vld_s = 1'b0;
                grant_id_s  = 1'b0;
            end
        endcase
        if ((state_q == IDLE) && grant_vld_s) begin
            req_ready_s = grant_id_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Sequencer next-state and datapath captures.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctl_d     = op_ctl_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_id_d     = rsp_id_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                if (grant_vld_s) begin
                    op_a_d       = grant_id_s ? req_a1 : req_a0;
                    op_b_d       = grant_id_s ? req_b1 : req_b0;
                    op_ctl_d     = grant_id_s ? req_op1 : req_op0;
                    rsp_id_d     = grant_id_s;
                    last_grant_d = grant_id_s;
                    state_d      = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result_s;
                rsp_zero_d   = alu_zero_s;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + {{(CNTW-1){1'b0}}, 1'b1};
                    state_d    = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= {WIDTH{1'b0}};
            op_b_q       <= {WIDTH{1'b0}};
            op_ctl_q     <= {OPW{1'b0}};
            rsp_result_q <= {WIDTH{1'b0}};
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            op_count_q   <= {CNTW{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_ctl_q     <= op_ctl_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req_ready  = req_ready_s;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = busy_q;
    assign op_count   = op_count_q;

endmodule
